// File: rtl/regfile_param_sb_if.sv
// Register-file bus: two read ports with busy flags, one write port,
// one reservation port and the register-0 view.
interface regfile_param_sb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] r1;
    logic [ADDR_W-1:0] r2;
    logic [DATA_W-1:0] r1out;
    logic [DATA_W-1:0] r2out;
    logic              r1busy;
    logic              r2busy;
    logic [ADDR_W-1:0] wDest;
    logic [DATA_W-1:0] wDat;
    logic              regWrt;
    logic [ADDR_W-1:0] rsvDest;
    logic              rsvEn;
    logic [DATA_W-1:0] m;

    modport master (
        output r1, r2, wDest, wDat, regWrt, rsvDest, rsvEn,
        input  r1out, r2out, r1busy, r2busy, m
    );

    modport slave (
        input  r1, r2, wDest, wDat, regWrt, rsvDest, rsvEn,
        output r1out, r2out, r1busy, r2busy, m
    );
endinterface

// File: rtl/regfile_param_sb.sv
// Parametrised register file with write-forwarding read ports and a
// per-register busy scoreboard; read ports optionally registered.
module regfile_param_sb #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 3,
    parameter int READ_REG  = 0,
    parameter int ZERO_REG0 = 0
) (
    input  logic               clk,
    input  logic               reset,
    regfile_param_sb_if.slave  bus
);
    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;

    logic              wr_en;
    logic              rsv_en;
    logic              hit1;
    logic              hit2;
    logic [DATA_W-1:0] b1;
    logic [DATA_W-1:0] b2;
    logic              s1;
    logic              s2;

    // Writes and reservations aimed at a hardwired register 0 are dropped.
    assign wr_en  = bus.regWrt && !((ZERO_REG0 != 0) && (bus.wDest == '0));
    assign rsv_en = bus.rsvEn  && !((ZERO_REG0 != 0) && (bus.rsvDest == '0));

    assign hit1 = wr_en && (bus.wDest == bus.r1);
    assign hit2 = wr_en && (bus.wDest == bus.r2);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        b1 = regs[bus.r1];
        b2 = regs[bus.r2];
        if (hit1) b1 = bus.wDat;
        if (hit2) b2 = bus.wDat;
        s1 = busy[bus.r1] && !hit1;
        s2 = busy[bus.r2] && !hit2;
    end

    // NOTE: the register array is explicitly reset because m and the read
    // ports must never show X after the first reset; state uses <= only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_en) regs[bus.wDest] <= bus.wDat;
            // Clear first, then set: a new reservation belongs to a later producer.
            if (wr_en)  busy[bus.wDest]   <= 1'b0;
            if (rsv_en) busy[bus.rsvDest] <= 1'b1;
        end
    end

    assign bus.m = regs[0];

    generate
        if (READ_REG == 0) begin : g_comb_read
            assign bus.r1out  = b1;
            assign bus.r2out  = b2;
            assign bus.r1busy = s1;
            assign bus.r2busy = s2;
        end else begin : g_reg_read
            always_ff @(posedge clk) begin
                if (!reset) begin
                    bus.r1out  <= '0;
                    bus.r2out  <= '0;
                    bus.r1busy <= 1'b0;
                    bus.r2busy <= 1'b0;
                end else begin
                    bus.r1out  <= b1;
                    bus.r2out  <= b2;
                    bus.r1busy <= s1;
                    bus.r2busy <= s2;
                end
            end
        end
    endgenerate
endmodule
